radix_multiplier: RTL

- Iterative unsigned WIDTH x WIDTH multiplier that consumes DIGIT_BITS bits of the multiplier operand per cycle.
- Next-generation replacement for the 1-bit-per-cycle shift-add multiplier used in key generation.
- Adds operand latching, a proper ready/valid handshake, configurable throughput/area trade-off, and clean abort on reset.
- Sits between the key-generation controller and the modular-arithmetic datapath.

---
 rtl/radix_multiplier_pkg.sv | 21 ++
 rtl/radix_multiplier_digit_partial_product.sv | 21 ++
 rtl/radix_multiplier.sv | 123 ++++++++++++
 3 files changed

// File: rtl/radix_multiplier_pkg.sv
// Shared types and helpers for the radix-2^DIGIT_BITS iterative multiplier.
package mult_pkg;

    typedef enum logic [0:0] {MULT_IDLE, MULT_COMPUTE} mult_state_t;

    localparam int unsigned DIGIT_BITS_1 = 1;
    localparam int unsigned DIGIT_BITS_2 = 2;
    localparam int unsigned DIGIT_BITS_4 = 4;
    localparam int unsigned DIGIT_BITS_8 = 8;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit_bits);
        return width / digit_bits;
    endfunction

    function automatic bit digit_bits_legal(input int unsigned digit_bits);
        return (digit_bits == DIGIT_BITS_1) || (digit_bits == DIGIT_BITS_2) ||
               (digit_bits == DIGIT_BITS_4) || (digit_bits == DIGIT_BITS_8);
    endfunction

endpackage

// File: rtl/radix_multiplier_digit_partial_product.sv
// Combinational (2*WIDTH) x DIGIT_BITS partial product, truncated to 2*WIDTH bits.
module digit_partial_product #(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned DIGIT_BITS = 4
) (
    input  logic [2*WIDTH-1:0]    a_i,
    input  logic [DIGIT_BITS-1:0] digit_i,
    output logic [2*WIDTH-1:0]    pp_o
);

    // Shift-and-add over the digit bits keeps the cone to DIGIT_BITS adders.
    always_comb begin
        pp_o = '0;
        for (int unsigned i = 0; i < DIGIT_BITS; i++) begin
            if (digit_i[i]) begin
                pp_o = pp_o + (a_i << i);
            end
        end
    end

endmodule

// File: rtl/radix_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier, DIGIT_BITS multiplier bits per cycle.
// Optional: define RADIX_MULT_EARLY_TERM_EN to finish once the remaining multiplier bits are zero.
module radix_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned DIGIT_BITS = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [2*WIDTH-1:0] c_out,
    output logic               valid_out
);

    localparam int unsigned NUM_DIGITS = num_digits(WIDTH, DIGIT_BITS);
    localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam int unsigned PW         = 2 * WIDTH;

    generate
        if (WIDTH % DIGIT_BITS != 0) begin : g_bad_width
            $error("radix_multiplier: WIDTH must be a multiple of DIGIT_BITS");
        end
        if (!digit_bits_legal(DIGIT_BITS)) begin : g_bad_digit
            $error("radix_multiplier: DIGIT_BITS must be 1, 2, 4 or 8");
        end
    endgenerate

    mult_state_t      state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    c_q, c_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;
    logic [WIDTH-1:0] b_shift;
    logic             finish;

    digit_partial_product #(
        .WIDTH      (WIDTH),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_pp (
        .a_i     (a_q),
        .digit_i (b_q[DIGIT_BITS-1:0]),
        .pp_o    (pp)
    );

    always_comb begin
        acc_sum = acc_q + pp;
        b_shift = b_q >> DIGIT_BITS;
`ifdef RADIX_MULT_EARLY_TERM_EN
        finish  = (cnt_q == CNT_W'(NUM_DIGITS - 1)) || (b_shift == '0);
`else
        finish  = (cnt_q == CNT_W'(NUM_DIGITS - 1));
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= MULT_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        valid_d = 1'b0;
        case (state_q)
            MULT_IDLE: begin
                if (valid_in) begin
                    a_d     = {{WIDTH{1'b0}}, a_in};
                    b_d     = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MULT_COMPUTE;
                end
            end
            MULT_COMPUTE: begin
                acc_d = acc_sum;
                a_d   = a_q << DIGIT_BITS;
                b_d   = b_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (finish) begin
                    c_d     = acc_sum;
                    valid_d = 1'b1;
                    state_d = MULT_IDLE;
                end
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == MULT_IDLE);
        c_out     = c_q;
        valid_out = valid_q;
    end

endmodule
